seg_scan_mux: RTL and testbench

Parametrised multiplexed seven-segment scanner. It succeeds the fixed 8-digit anode rotator and adds an integrated prescaler, per-digit enable mask with skip, leading-zero blanking, PWM brightness and an inter-digit ghost-guard blank. It sits between the display-data registers and the board's active-low Anode/Cathode pins and drives the complete display on its own.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/hex_to_seg.sv | 12 +
 rtl/seg_scan_mux.sv | 86 ++++++++
 tb/tb_seg_scan_mux.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit order, hex glyph table, clog2.
// Pure declarations; no timing or flow control.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Bit positions within the active-low {g,f,e,d,c,b,a} segment word
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Nibble to active-low seven-segment glyph.
// Combinational, zero latency; no backpressure.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner: prescaler, enable-mask skip, leading-zero blank, PWM, ghost guard.
// All pin outputs registered (1 cycle); free-running, no backpressure.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 4
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [4*NUM_DIGITS-1:0]       digits,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          lzb,
    input  logic [BRIGHT_W-1:0]           brightness,
    output logic [NUM_DIGITS-1:0]         Anode,
    output logic [6:0]                    Cathode,
    output logic                          dp_n,
    output logic [clog2(NUM_DIGITS)-1:0]  digit_sel,
    output logic                          scan_tick
);

    localparam int SEL_W = clog2(NUM_DIGITS);
    localparam int CNT_W = clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]      slot_cnt;
    logic [SEL_W-1:0]      next_sel;
    logic [SEL_W:0]        cand;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg;
    logic                  guard_done;
    logic                  pwm_on;
    logic                  lit;

    assign scan_tick = (slot_cnt == LAST_CNT);

    // Digit i is blanked when it and every digit above it are zero; digit 0 always shows.
    assign blank_mask[0] = 1'b0;
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lzb
        assign blank_mask[i] = lzb && (digits[4*NUM_DIGITS-1:4*i] == '0);
    end

    // Cyclic search upward from the current digit; the smallest step that hits an
    // enabled digit wins, and step NUM_DIGITS lands back on the current digit.
    always_comb begin
        next_sel = digit_sel;
        cand     = '0;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            cand = {1'b0, digit_sel} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(NUM_DIGITS)) cand = cand - (SEL_W+1)'(NUM_DIGITS);
            if (digit_en[cand[SEL_W-1:0]]) next_sel = cand[SEL_W-1:0];
        end
    end

    assign cur_nibble = digits[{digit_sel, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    assign guard_done = int'(slot_cnt) >= BLANK_CYCLES;
    assign pwm_on     = (&brightness) || (slot_cnt[BRIGHT_W-1:0] < brightness);
    assign lit        = digit_en[digit_sel] && guard_done && pwm_on;

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_sel <= '0;
            Anode     <= '1;
            Cathode   <= SEG_OFF;
            dp_n      <= 1'b1;
        end else begin
            slot_cnt <= scan_tick ? '0 : slot_cnt + CNT_W'(1);
            if (scan_tick) digit_sel <= next_sel;
            Anode    <= lit ? ~(NUM_DIGITS'(1) << digit_sel) : '1;
            Cathode  <= blank_mask[digit_sel] ? SEG_OFF : cur_seg;
            dp_n     <= ~dp_in[digit_sel];
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a slot/digit reference model queues the expected pins per cycle,
// a monitor pops and compares one entry after every clock edge.
module tb_seg_scan_mux;

    localparam int N  = 4;
    localparam int TD = 32;
    localparam int BC = 4;
    localparam int BW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        lzb = 1'b0;
    logic [3:0]  brightness = '0;
    logic [3:0]  Anode;
    logic [6:0]  Cathode;
    logic        dp_n;
    logic [1:0]  digit_sel;
    logic        scan_tick;

    seg_scan_mux #(
        .NUM_DIGITS   (N),
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC),
        .BRIGHT_W     (BW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lzb        (lzb),
        .brightness (brightness),
        .Anode      (Anode),
        .Cathode    (Cathode),
        .dp_n       (dp_n),
        .digit_sel  (digit_sel),
        .scan_tick  (scan_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] anode;
        logic [6:0] cathode;
        logic       dp_n;
        logic [1:0] sel;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_slot = 0;   // model position within the current slot
    int   m_sel = 0;    // model digit being scanned

    function automatic logic [6:0] hexseg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Issue one cycle: the inputs currently set plus rst are what the DUT samples at the next edge.
    task automatic step(input logic rst);
        exp_t        e;
        logic [15:0] sh;
        logic        lit;
        reset = rst;
        if (rst) begin
            e.anode   = 4'hF;
            e.cathode = 7'h7F;
            e.dp_n    = 1'b1;
            m_slot    = 0;
            m_sel     = 0;
        end else begin
            lit = digit_en[m_sel] && (m_slot >= BC) &&
                  (brightness == 4'hF || (m_slot % 16) < int'(brightness));
            e.anode   = lit ? ~(4'b0001 << m_sel) : 4'hF;
            sh        = digits >> (4 * m_sel);
            e.cathode = (lzb && m_sel > 0 && sh == 16'h0) ? 7'h7F : hexseg(sh[3:0]);
            e.dp_n    = ~dp_in[m_sel];
            if (m_slot == TD - 1) begin
                m_slot = 0;
                for (int k = 1; k <= N; k++) begin
                    if (digit_en[(m_sel + k) % N]) begin
                        m_sel = (m_sel + k) % N;
                        break;
                    end
                end
            end else begin
                m_slot++;
            end
        end
        e.sel  = 2'(m_sel);
        e.tick = (m_slot == TD - 1);
        q.push_back(e);
        @(negedge clock);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("anode", 32'(Anode), 32'(e.anode));
            check("cathode", 32'(Cathode), 32'(e.cathode));
            check("dp_n", 32'(dp_n), 32'(e.dp_n));
            check("digit_sel", 32'(digit_sel), 32'(e.sel));
            check("scan_tick", 32'(scan_tick), 32'(e.tick));
        end
    end

    initial begin
        int guard;
        @(negedge clock);
        digit_en = 4'hF; brightness = 4'hF; digits = 16'h1234;
        repeat (3) step(1'b1);
        repeat (256) step(1'b0);

        digit_en = 4'b0101;
        repeat (160) step(1'b0);
        digit_en = 4'b0000;
        repeat (80) step(1'b0);

        digit_en = 4'hF; lzb = 1'b1; digits = 16'h0070;
        repeat (130) step(1'b0);
        digits = 16'h0000; dp_in = 4'b1000;
        repeat (130) step(1'b0);

        lzb = 1'b0; dp_in = 4'b0000; digits = 16'h1234; brightness = 4'h4;
        repeat (130) step(1'b0);
        brightness = 4'h0;
        repeat (130) step(1'b0);

        brightness = 4'hF;
        guard = 0;
        while (!(m_slot == 20 && m_sel == 2) && guard < 200) begin
            step(1'b0);
            guard++;
        end
        step(1'b1);
        repeat (40) step(1'b0);

        repeat (3000) begin
            if ($urandom_range(0, 15) == 0)
                digits = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lzb = 1'($urandom);
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
            step($urandom_range(0, 499) == 0);
        end

        repeat (2) @(posedge clock);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
